edge_event_unit: RTL and testbench
==================================

Name: edge_event_unit

Overview:
Multi-channel successor to the single-level edge detector, for asynchronous inputs such as buttons, sensor strobes and external interrupts. Per channel it:
- synchronises the raw input
- rejects glitches with a stability filter
- detects edges in a selectable mode
- records qualifying edges in sticky pending flags and saturating event counters, with a combined interrupt

It sits between the FPGA input pins and the register/interrupt logic.

Parameters:
CHANNELS, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
FILTER_CYCLES, 4, consecutive stable cycles needed to accept a new level (>=1; 1 = no filtering)
COUNT_WIDTH, 8, width of each per-channel event counter (>=1)

Ports:
clk  input  1  sole clock; all state updates on rising edge
reset_low  input  1  asynchronous, active-low reset
level  input  CHANNELS  raw asynchronous inputs, bit i = channel i
mode  input  2*CHANNELS  per-channel edge mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 any
clear  input  CHANNELS  per-channel clear strobe, sampled each cycle
filtered_level  output  CHANNELS  debounced level per channel
edge_pulse  output  CHANNELS  one-cycle pulse per qualifying edge
pending  output  CHANNELS  sticky qualifying-edge flags
count  output  COUNT_WIDTH*CHANNELS  saturating event counts, channel i at [COUNT_WIDTH*(i+1)-1 : COUNT_WIDTH*i]
irq  output  1  OR of all pending bits

Behaviour:
- Reset (reset_low low, asynchronous, immediate): every register is cleared. This covers the synchroniser chains, filter counters, filtered_level, edge_pulse, pending and count. irq is 0. Reset asserted mid-operation discards in-progress filtering immediately.
- Synchroniser: level[i] passes through SYNC_STAGES flops; the last stage is s[i]. No logic acts on level before the last stage.
- Filter, per channel: an up-counter of width clog2(FILTER_CYCLES)+1.
  - s == filtered_level: counter cleared to 0.
  - s != filtered_level and counter < FILTER_CYCLES-1: counter increments.
  - s != filtered_level and counter == FILTER_CYCLES-1: filtered_level <= s, counter <= 0.
  - A return to the old level before acceptance clears the counter; no edge is produced.
- Latency: a level change first captured at edge 0 appears on filtered_level after edge SYNC_STAGES+FILTER_CYCLES-1. edge_pulse is asserted in that same cycle.
- Edge qualification, registered and updated on the same edge as filtered_level:
  - Rising edge = filtered_level 0->1; falling edge = 1->0.
  - The edge qualifies if mode is 11, or 01 and rising, or 10 and falling. Mode 00 never qualifies.
  - edge_pulse[i] is high for exactly one cycle per qualifying edge.
- Mode changes take effect for edges accepted from the next clock edge onward. The filter and filtered_level track the input regardless of mode, including mode 00. A mode change never generates an event by itself.
- pending[i]: set by a qualifying edge, cleared by clear[i]=1. When both occur in the same cycle, set wins and pending stays 1.
- count[i]:
  - Increments by 1 per qualifying edge and saturates at 2^COUNT_WIDTH-1 (no wrap).
  - clear[i] zeroes it.
  - A qualifying edge and clear in the same cycle give count = 1.
- irq = OR of pending, decoded from registered values (no extra latency).
- Reset-release boundary: filtered_level resets to 0. An input held high through reset release is therefore accepted as a rising edge after the normal latency.
- Channels are fully independent; simultaneous events on several channels are all recorded in the same cycle.

Test Plan:
All scenarios use defaults unless stated.

1. Release reset, ch0 mode=01, level[0] 0->1 held.
   -> filtered_level[0] and edge_pulse[0] rise 5 edges after capture; edge_pulse[0] lasts one cycle; pending[0]=1, count0=1, irq=1.
2. Ch1 mode=11, level[1] high for 3 cycles then low.
   -> filtered_level[1] stays 0; no edge_pulse; pending[1]=0, count1=0.
3. Ch2 mode=10, level[2] rises then falls, each held 10 cycles.
   -> only the fall pulses edge_pulse[2]; count2=1; filtered_level[2] still follows both transitions.
4. Ch3 pending=1, count3=5; clear[3] pulsed in the same cycle as a new qualifying edge.
   -> pending[3]=1, count3=1. Clear alone one cycle later -> pending[3]=0, count3=0, irq=0 if no other pending.
5. COUNT_WIDTH=2, ch4 mode=11, 5 accepted transitions.
   -> count4 sequence 1,2,3,3,3; five edge_pulse cycles.
6. Assert reset_low low between clock edges while ch5 is mid-filter with pending[5]=1.
   -> all outputs 0 before the next clock edge. After release with level[5] held high -> rising edge accepted after the normal latency.

Source files
------------

// File: rtl/edge_event_unit_if.sv
// Signal bundle between the pin-side edge/event unit and its register/interrupt consumer.
// The master side drives the raw levels and controls; the slave side is the event unit.
interface edge_event_unit_if #(
  parameter int CHANNELS    = 8,
  parameter int COUNT_WIDTH = 8
);
  logic [CHANNELS-1:0]             level;
  logic [2*CHANNELS-1:0]           mode;
  logic [CHANNELS-1:0]             clear;
  logic [CHANNELS-1:0]             filtered_level;
  logic [CHANNELS-1:0]             edge_pulse;
  logic [CHANNELS-1:0]             pending;
  logic [COUNT_WIDTH*CHANNELS-1:0] count;
  logic                            irq;

  modport master (
    output level, mode, clear,
    input  filtered_level, edge_pulse, pending, count, irq
  );

  modport slave (
    input  level, mode, clear,
    output filtered_level, edge_pulse, pending, count, irq
  );
endinterface

// File: rtl/edge_event_unit.sv
// Multi-channel input conditioner: synchroniser, stability filter, mode-selected edge
// detection, sticky pending flags, saturating event counters and a combined interrupt.
module edge_event_unit #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic           clk,
  input  logic           reset_low,
  edge_event_unit_if.slave bus
);

  localparam int                     FW       = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FW-1:0]          FLT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0]          sync_q    [CHANNELS];
  logic [FW-1:0]                   flt_cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0]          cnt_q     [CHANNELS];
  logic [CHANNELS-1:0]             filt_q;
  logic [CHANNELS-1:0]             pulse_q;
  logic [CHANNELS-1:0]             pend_q;

  logic [CHANNELS-1:0]             sync_lvl;
  logic [CHANNELS-1:0]             accept;
  logic [CHANNELS-1:0]             qual;
  logic [COUNT_WIDTH*CHANNELS-1:0] count_flat;

  // rise is the newly accepted level: 1 means a 0->1 transition
  function automatic logic mode_match(input logic [1:0] m, input logic rise);
    case (m)
      2'b01:   return rise;
      2'b10:   return !rise;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    sync_lvl = '0;
    accept   = '0;
    qual     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_lvl[i] = sync_q[i][SYNC_STAGES-1];
      accept[i]   = (sync_lvl[i] != filt_q[i]) && (flt_cnt_q[i] == FLT_LAST);
      qual[i]     = accept[i] && mode_match(bus.mode[2*i +: 2], sync_lvl[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]    <= '0;
        flt_cnt_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
      filt_q  <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.level[i]};

        // the filter runs in every mode so filtered_level always tracks the pin
        if (sync_lvl[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (accept[i]) begin
          filt_q[i]    <= sync_lvl[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end

        pulse_q[i] <= qual[i];

        if (qual[i]) begin
          pend_q[i] <= 1'b1;
        end else if (bus.clear[i]) begin
          pend_q[i] <= 1'b0;
        end

        // a clear coinciding with a new event leaves exactly that one event counted
        if (bus.clear[i]) begin
          cnt_q[i] <= qual[i] ? CNT_ONE : '0;
        end else if (qual[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_flat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_flat[COUNT_WIDTH*i +: COUNT_WIDTH] = cnt_q[i];
    end
  end

  assign bus.filtered_level = filt_q;
  assign bus.edge_pulse     = pulse_q;
  assign bus.pending        = pend_q;
  assign bus.count          = count_flat;
  assign bus.irq            = |pend_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// Directed bench for edge_event_unit: latency, glitch rejection, edge modes, clear/set
// priority, counter saturation and asynchronous reset behaviour.
module tb_edge_event_unit;

  logic clk;
  logic reset_low;

  int n_assert = 0;
  int n_fail   = 0;

  edge_event_unit_if #(.CHANNELS(8), .COUNT_WIDTH(8)) bus_a ();
  edge_event_unit_if #(.CHANNELS(8), .COUNT_WIDTH(2)) bus_b ();

  edge_event_unit #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .COUNT_WIDTH(8)) dut_a (
    .clk       (clk),
    .reset_low (reset_low),
    .bus       (bus_a)
  );

  edge_event_unit #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .COUNT_WIDTH(2)) dut_b (
    .clk       (clk),
    .reset_low (reset_low),
    .bus       (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance n clock edges, landing 1 time unit after the last rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [1:0] exp5 [5];
  int         pulses;
  int         pulse_at;

  initial begin
    exp5 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset_low   = 1'b0;
    bus_a.level = '0;
    bus_a.mode  = '0;
    bus_a.clear = '0;
    bus_b.level = '0;
    bus_b.mode  = '0;
    bus_b.clear = '0;

    tick(2);
    chk("rst_filtered", 64'(bus_a.filtered_level), 64'h0);
    chk("rst_pulse",    64'(bus_a.edge_pulse),     64'h0);
    chk("rst_pending",  64'(bus_a.pending),        64'h0);
    chk("rst_count",    64'(bus_a.count),          64'h0);
    chk("rst_irq",      64'(bus_a.irq),            64'h0);

    reset_low = 1'b1;
    bus_a.mode[1:0]   = 2'b01;
    bus_a.mode[3:2]   = 2'b11;
    bus_a.mode[5:4]   = 2'b10;
    bus_a.mode[7:6]   = 2'b11;
    bus_a.mode[11:10] = 2'b11;
    bus_b.mode[9:8]   = 2'b11;

    // 1: rising edge latency on ch0
    bus_a.level[0] = 1'b1;
    tick(5);
    chk("t1_filt_before", 64'(bus_a.filtered_level[0]), 64'h0);
    chk("t1_pulse_before", 64'(bus_a.edge_pulse[0]),    64'h0);
    tick(1);
    chk("t1_filt",    64'(bus_a.filtered_level[0]), 64'h1);
    chk("t1_pulse",   64'(bus_a.edge_pulse),        64'h01);
    chk("t1_pending", 64'(bus_a.pending),           64'h01);
    chk("t1_count0",  64'(bus_a.count[7:0]),        64'h1);
    chk("t1_irq",     64'(bus_a.irq),               64'h1);
    tick(1);
    chk("t1_pulse_end", 64'(bus_a.edge_pulse[0]), 64'h0);
    chk("t1_count0_hold", 64'(bus_a.count[7:0]),  64'h1);

    // 2: 3-cycle glitch on ch1 is rejected
    bus_a.level[1] = 1'b1;
    tick(3);
    bus_a.level[1] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (bus_a.edge_pulse[1] || bus_a.filtered_level[1]) pulses++;
    end
    chk("t2_activity", 64'(pulses),               64'd0);
    chk("t2_pending1", 64'(bus_a.pending[1]),     64'h0);
    chk("t2_count1",   64'(bus_a.count[15:8]),    64'h0);

    // 3: falling-only mode on ch2
    bus_a.level[2] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (bus_a.edge_pulse[2]) pulses++;
    end
    chk("t3_rise_filt",    64'(bus_a.filtered_level[2]), 64'h1);
    chk("t3_rise_pulses",  64'(pulses),                  64'd0);
    chk("t3_rise_pending", 64'(bus_a.pending[2]),        64'h0);
    bus_a.level[2] = 1'b0;
    pulses   = 0;
    pulse_at = -1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (bus_a.edge_pulse[2]) begin
        pulses++;
        pulse_at = k;
      end
    end
    chk("t3_fall_filt",    64'(bus_a.filtered_level[2]), 64'h0);
    chk("t3_fall_pulses",  64'(pulses),                  64'd1);
    chk("t3_fall_latency", 64'(pulse_at),                64'd6);
    chk("t3_count2",       64'(bus_a.count[23:16]),      64'h1);
    chk("t3_pending2",     64'(bus_a.pending[2]),        64'h1);

    // 4: clear priority on ch3; first drop the other pending flags
    bus_a.clear = 8'b0000_0101;
    tick(1);
    bus_a.clear = '0;
    chk("t4_pre_pending", 64'(bus_a.pending), 64'h0);
    chk("t4_pre_irq",     64'(bus_a.irq),     64'h0);
    chk("t4_pre_count0",  64'(bus_a.count[7:0]), 64'h0);
    for (int k = 0; k < 5; k++) begin
      bus_a.level[3] = ~bus_a.level[3];
      tick(10);
    end
    chk("t4_count3_five", 64'(bus_a.count[31:24]), 64'd5);
    chk("t4_pending3",    64'(bus_a.pending[3]),   64'h1);
    bus_a.level[3] = 1'b0;
    tick(5);
    bus_a.clear[3] = 1'b1;
    tick(1);
    chk("t4_coinc_pulse",   64'(bus_a.edge_pulse[3]), 64'h1);
    chk("t4_coinc_pending", 64'(bus_a.pending[3]),    64'h1);
    chk("t4_coinc_count",   64'(bus_a.count[31:24]),  64'h1);
    tick(1);
    bus_a.clear[3] = 1'b0;
    chk("t4_clr_pending", 64'(bus_a.pending[3]),   64'h0);
    chk("t4_clr_count",   64'(bus_a.count[31:24]), 64'h0);
    chk("t4_clr_irq",     64'(bus_a.irq),          64'h0);

    // 5: 2-bit counter saturation on dut_b ch4
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      bus_b.level[4] = ~bus_b.level[4];
      for (int j = 0; j < 10; j++) begin
        tick(1);
        if (bus_b.edge_pulse[4]) pulses++;
      end
      chk($sformatf("t5_count4_%0d", k), 64'(bus_b.count[9:8]), 64'(exp5[k]));
    end
    chk("t5_pulses", 64'(pulses), 64'd5);

    // 6: async reset mid-filter on ch5, level held high through release
    bus_a.level[5] = 1'b1;
    tick(10);
    chk("t6_pending5", 64'(bus_a.pending[5]), 64'h1);
    bus_a.level[5] = 1'b0;
    tick(3);
    #2;
    reset_low = 1'b0;
    #1;
    chk("t6_rst_filtered", 64'(bus_a.filtered_level), 64'h0);
    chk("t6_rst_pending",  64'(bus_a.pending),        64'h0);
    chk("t6_rst_count",    64'(bus_a.count),          64'h0);
    chk("t6_rst_irq",      64'(bus_a.irq),            64'h0);
    bus_a.level[5] = 1'b1;
    tick(1);
    reset_low = 1'b1;
    tick(5);
    chk("t6_filt_before", 64'(bus_a.filtered_level), 64'h00);
    tick(1);
    chk("t6_filt_after", 64'(bus_a.filtered_level), 64'h21);
    chk("t6_pulse",      64'(bus_a.edge_pulse),     64'h21);
    chk("t6_count5",     64'(bus_a.count[47:40]),   64'h1);
    chk("t6_irq",        64'(bus_a.irq),            64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
